alu_seq: RTL
============

Name: alu_seq

Overview:
- Multi-cycle ALU stage directly downstream of accumulator register A; consumes A's output as operand A and a second 16-bit operand B.
- Start/done handshake toward the CPU control sequencer. Its result feeds back to A's data input; the sequencer drives A's load strobe on done.
- Single-pass logic/arithmetic ops plus a 16-iteration shift-add multiply.

Parameters:
- WIDTH, 16, operand/result width; only 16 is verified.
- MUL_ITER, WIDTH, multiply iteration count; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  opcode, latched with start
- dataA  in  16  operand A, from register A output
- dataB  in  16  operand B
- busy  out  1  high in EXEC, MUL, DONE
- done  out  1  one-cycle pulse: result and flags valid
- result  out  16  low result word
- result_hi  out  16  MUL upper word; 0 for other ops
- carry  out  1  ADD carry-out, SUB borrow, SHL bit shifted out; 0 otherwise
- zero  out  1  result==0 (MUL: full 32-bit product==0)
- illegal  out  1  set with done for an unsupported opcode

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, carry, zero, illegal=0; result, result_hi=0; iteration counter=0. Reset mid-operation aborts with no done pulse.
- Opcodes:
  - 000 ADD, 001 SUB (A-B), 010 AND, 011 OR
  - 100 XOR, 101 NOT A, 110 SHL1 A (LSB in 0)
  - 111 MUL: unsigned, 32-bit product {result_hi,result}
- All arithmetic is modulo 2^16; carry is bit 16 of the 17-bit ADD/SUB.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE & start=1 at edge N: latch op, dataA, dataB. Go to MUL if op==111, else EXEC.
  - EXEC: compute; next edge to DONE.
  - MUL: each edge adds the multiplicand if multiplier LSB=1, then shifts. Counter runs 0..MUL_ITER-1; after iteration 15, go to DONE.
  - DONE: done=1 for exactly one cycle; next edge to IDLE.
- Latency, start sampled at edge N:
  - Non-MUL: done high in the cycle following edge N+2.
  - MUL: done high following edge N+17.
- result, result_hi, flags are registered and hold their values until the next completion. They do not change while busy.
- start while busy is ignored and not queued. Operand changes after edge N have no effect.
- start held high continuously: a new op is accepted in the first IDLE cycle, at edge N+3 for non-MUL ops.
- done and start coincide only across distinct states; there is no same-cycle restart from DONE.

Optional Feature:
- Macro ALU_MUL_EN.
  - Defined: MUL datapath and MUL state present; illegal is always 0.
  - Undefined: op 111 is routed through EXEC with latency identical to the other ops. Outputs: result=0, result_hi=0, carry=0, zero=1, illegal=1 with done.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_MUL)
  - FSM state encoding
  - WIDTH default
- One sub-module, alu_mul_shift_add: sequential multiplier holding multiplicand, multiplier, and product registers plus the iteration counter.
  - Interface: load, step, last.
  - Instantiated only under ALU_MUL_EN.

Test Plan:
- Reset mid-MUL: rst_n pulled low at cycle 8 of a MUL -> all outputs 0 asynchronously, no done; a following ADD completes normally.
- ADD: A=0x00FE, B=0x0FE6 -> done 2 cycles after start; result=0x10E4, carry=0, zero=0.
- SUB borrow and ADD wrap:
  - SUB A=0x0005, B=0x0007 -> result=0xFFFE, carry=1.
  - ADD 0xFFFF+0x0001 -> result=0x0000, carry=1, zero=1.
- MUL: A=0x00FE, B=0x0FE6 -> done 17 cycles after start; result_hi=0x000F, result=0xC634, zero=0.
- Busy rejection: start a MUL, then pulse start with op=ADD at busy cycle 5 -> ignored, single done with the MUL result. SHL1 A=0x8001 -> result=0x0002, carry=1.
- Without ALU_MUL_EN: op=111 -> done after 2 cycles, illegal=1, result=0, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_seq shared definitions: opcodes, FSM state encoding, default width.
// Imported by alu_seq and alu_mul_shift_add.
package alu_pkg;

   localparam int WIDTH_DEF = 16;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/alu_mul_shift_add.sv
// Sequential shift-add unsigned multiplier, one partial product per step.
// Ports: load (capture operands, clear product/counter), step (one
// iteration), mcand_i/mplier_i operands, product_o, last (final step).
module alu_mul_shift_add
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ITER  = WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcand_i,
   input  logic [WIDTH-1:0]   mplier_i,
   output logic [2*WIDTH-1:0] product_o,
   output logic               last
);

   localparam int CW = $clog2(ITER);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      if (load) begin
         mcand_d  = {{WIDTH{1'b0}}, mcand_i};
         mplier_d = mplier_i;
         prod_d   = '0;
         cnt_d    = '0;
      end else if (step) begin
         // Multiplicand walks left so each bit's weight is implicit.
         if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
      end
   end

   assign product_o = prod_q;
   assign last      = (cnt_q == CW'(ITER - 1));

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU stage with start/done handshake; ALU_MUL_EN adds MUL.
// Ports: start/op/dataA/dataB in; busy, done, result, result_hi, flags out.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int MUL_ITER = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             zero,
   output logic             illegal
);

   if (MUL_ITER != WIDTH) begin : g_iter_chk
      $error("MUL_ITER must equal WIDTH");
   end

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [WIDTH:0]   sum_w, diff_w;

`ifdef ALU_MUL_EN
   logic               mul_load, mul_step, mul_last;
   logic [2*WIDTH-1:0] mul_prod;

   alu_mul_shift_add #(
      .WIDTH (WIDTH),
      .ITER  (MUL_ITER)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (mul_load),
      .step      (mul_step),
      .mcand_i   (dataA),
      .mplier_i  (dataB),
      .product_o (mul_prod),
      .last      (mul_last)
   );
`endif

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      done_d      = 1'b0;
      sum_w       = {1'b0, a_q} + {1'b0, b_q};
      diff_w      = {1'b0, a_q} - {1'b0, b_q};
`ifdef ALU_MUL_EN
      mul_load    = 1'b0;
      mul_step    = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               a_d     = dataA;
               b_d     = dataB;
               state_d = S_EXEC;
`ifdef ALU_MUL_EN
               if (op == OP_MUL) begin
                  state_d  = S_MUL;
                  mul_load = 1'b1;
               end
`endif
            end
         end
         S_EXEC: state_d = S_DONE;
         S_MUL: begin
`ifdef ALU_MUL_EN
            mul_step = 1'b1;
            if (mul_last) begin
               state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
         end
         S_DONE: begin
            // Outputs update on the edge leaving DONE, so they never
            // move while busy and line up with the done pulse.
            state_d     = S_IDLE;
            done_d      = 1'b1;
            result_hi_d = '0;
            carry_d     = 1'b0;
            illegal_d   = 1'b0;
            unique case (op_q)
               OP_ADD: {carry_d, result_d} = sum_w;
               OP_SUB: {carry_d, result_d} = diff_w;
               OP_AND: result_d = a_q & b_q;
               OP_OR:  result_d = a_q | b_q;
               OP_XOR: result_d = a_q ^ b_q;
               OP_NOT: result_d = ~a_q;
               OP_SHL: {carry_d, result_d} = {a_q, 1'b0};
               default: begin
`ifdef ALU_MUL_EN
                  result_d    = mul_prod[WIDTH-1:0];
                  result_hi_d = mul_prod[2*WIDTH-1:WIDTH];
`else
                  result_d  = '0;
                  illegal_d = 1'b1;
`endif
               end
            endcase
            zero_d = (result_d == '0) && (result_hi_d == '0);
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule
